// File: rtl/enemy_attack_ctrl_pkg.sv
// Shared types and sizing helpers for the enemy attack controller.
package boxhead_pkg;

    typedef enum logic [1:0] {PLAY, HIT, OVER} atk_state_t;

    localparam int N_ENEMY_DEF = 4;
    localparam int HP_W        = 8;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/enemy_attack_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, wrapping.
module rr_arbiter
    import boxhead_pkg::*;
#(
    parameter int N  = N_ENEMY_DEF,
    parameter int PW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] gnt_idx_o,
    output logic          any_o
);

    always_comb begin
        logic          found;
        logic [PW-1:0] sel;
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        sel       = '0;
        for (int k = 0; k < N; k++) begin
            sel = PW'((int'(ptr_i) + k) % N);
            if (!found && req_i[sel]) begin
                found      = 1'b1;
                gnt_o[sel] = 1'b1;
                gnt_idx_o  = sel;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/enemy_attack_ctrl.sv
// Melee hit arbitration on the player: per-enemy cooldown, post-hit invincibility, HP and game over.
module enemy_attack_ctrl
    import boxhead_pkg::*;
#(
    parameter int N_ENEMY         = N_ENEMY_DEF,
    parameter int HP_MAX          = 100,
    parameter int DAMAGE          = 5,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int HIT_FRAMES      = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               Game_Start,
    input  logic [N_ENEMY-1:0] Enemy_Attack_Ready,
    input  logic [N_ENEMY-1:0] Enemy_Alive,
    output logic [HP_W-1:0]    Player_HP,
    output logic               Player_Hit,
    output logic               Game_Over,
    output logic [N_ENEMY-1:0] Attack_Grant,
    output logic [1:0]         dbg_state_o
);

    localparam int PW = idx_w(N_ENEMY);
    localparam int CW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam int HW = $clog2(HIT_FRAMES + 1);

    atk_state_t         state_q;
    logic [HP_W-1:0]    hp_q;
    logic               hit_q;
    logic               over_q;
    logic [N_ENEMY-1:0] grant_q;
    logic [PW-1:0]      rr_ptr_q;
    logic [HW-1:0]      hit_cnt_q;
    logic               frame_q1, frame_q2, tick_q;

    logic [N_ENEMY-1:0] cd_zero;
    logic [N_ENEMY-1:0] eligible;
    logic [N_ENEMY-1:0] gnt;
    logic [PW-1:0]      gnt_idx;
    logic               any_elig;
    logic               grant_fire;
    logic [HP_W-1:0]    hp_d;
    logic [PW-1:0]      rr_ptr_d;

    // Two-stage sample of the slow frame clock; tick lands 2 Clk after its rise.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            frame_q1 <= 1'b0;
            frame_q2 <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            frame_q1 <= frame_clk;
            frame_q2 <= frame_q1;
            tick_q   <= frame_q1 & ~frame_q2;
        end
    end

    assign eligible   = Enemy_Attack_Ready & Enemy_Alive & cd_zero;
    assign grant_fire = tick_q & any_elig & (state_q == PLAY) & ~Game_Start;

    rr_arbiter #(.N(N_ENEMY), .PW(PW)) u_arb (
        .req_i     (eligible),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_o     (any_elig)
    );

    for (genvar i = 0; i < N_ENEMY; i++) begin : g_cd
        logic [CW-1:0] cd_q;
        // A fresh grant reloads the counter and wins over the same-tick decrement.
        always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
                cd_q <= '0;
            end else if (Game_Start) begin
                cd_q <= '0;
            end else if (grant_fire && gnt[i]) begin
                cd_q <= CW'(COOLDOWN_FRAMES);
            end else if (tick_q && cd_q != '0) begin
                cd_q <= cd_q - CW'(1);
            end
        end
        assign cd_zero[i] = (cd_q == '0);
    end

    assign hp_d     = (hp_q > HP_W'(DAMAGE)) ? hp_q - HP_W'(DAMAGE) : '0;
    assign rr_ptr_d = (gnt_idx == PW'(N_ENEMY - 1)) ? '0 : gnt_idx + PW'(1);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= PLAY;
            hp_q      <= HP_W'(HP_MAX);
            hit_q     <= 1'b0;
            over_q    <= 1'b0;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            hit_cnt_q <= '0;
        end else begin
            grant_q <= '0;
            if (Game_Start) begin
                state_q   <= PLAY;
                hp_q      <= HP_W'(HP_MAX);
                hit_q     <= 1'b0;
                over_q    <= 1'b0;
                rr_ptr_q  <= '0;
                hit_cnt_q <= '0;
            end else begin
                case (state_q)
                    PLAY: begin
                        if (tick_q && any_elig) begin
                            grant_q   <= gnt;
                            hp_q      <= hp_d;
                            rr_ptr_q  <= rr_ptr_d;
                            hit_cnt_q <= HW'(HIT_FRAMES);
                            if (hp_d == '0) begin
                                state_q <= OVER;
                                over_q  <= 1'b1;
                            end else begin
                                state_q <= HIT;
                                hit_q   <= 1'b1;
                            end
                        end
                    end
                    HIT: begin
                        if (tick_q) begin
                            if (hit_cnt_q <= HW'(1)) begin
                                hit_cnt_q <= '0;
                                state_q   <= PLAY;
                                hit_q     <= 1'b0;
                            end else begin
                                hit_cnt_q <= hit_cnt_q - HW'(1);
                            end
                        end
                    end
                    OVER: begin
                        hit_q  <= 1'b0;
                        over_q <= 1'b1;
                    end
                    default: state_q <= PLAY;
                endcase
            end
        end
    end

    assign Player_HP    = hp_q;
    assign Player_Hit   = hit_q;
    assign Game_Over    = over_q;
    assign Attack_Grant = grant_q;
    assign dbg_state_o  = state_q;

endmodule
